// File: rtl/mem_responder.sv
// mem_responder: single-port word store answering data-mover requests.
//
// Reads sample the addressed word on accept, travel through READ_LATENCY
// pipeline stages and land in a response FIFO whose head drives rsp_*.
// Writes are byte-strobed and produce no response. A credit counter
// (reads in flight plus reads queued) throttles req_ready so the FIFO can
// never overflow. Out-of-range accesses set a sticky err_o.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_we, req_addr           1 = write / 0 = read, byte address
//   req_wdata, req_wstrb       write data and per-byte enables
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata                  read data (registered FIFO head)
//   err_o                      sticky out-of-range flag
//
// Optional feature: define MEM_RESPONDER_STALL_EN to AND a 16-bit
// Fibonacci LFSR bit into req_ready for pseudo-random back-pressure.

module mem_responder #(
  parameter int unsigned BUS_WIDTH_BYTES = 32,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned READ_LATENCY    = 2,
  parameter int unsigned RSP_FIFO_DEPTH  = 4,
  parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [8*BUS_WIDTH_BYTES-1:0] req_wdata,
  input  logic [BUS_WIDTH_BYTES-1:0]   req_wstrb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [8*BUS_WIDTH_BYTES-1:0] rsp_rdata,
  output logic                         err_o
);

  localparam int unsigned DW    = 8 * BUS_WIDTH_BYTES;
  localparam int unsigned OFFS  = $clog2(BUS_WIDTH_BYTES);
  localparam int unsigned IDXW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNTW  = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int unsigned SLOTW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

  // Parameter sanity checks at elaboration.
  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("mem_responder: READ_LATENCY must be >= 1");
  end
  if (RSP_FIFO_DEPTH < 1) begin : g_bad_depth
    $error("mem_responder: RSP_FIFO_DEPTH must be >= 1");
  end
  if (STALL_SEED == 16'h0000) begin : g_bad_seed
    $error("mem_responder: STALL_SEED of zero locks up the LFSR");
  end

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IDXW-1:0]       mem_idx;
  logic                  in_range;
  logic                  req_acc;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  credit_ok;
  logic [CNTW-1:0]       outstanding;

  assign word_idx  = req_addr >> OFFS;
  assign mem_idx   = word_idx[IDXW-1:0];
  assign in_range  = (32'(word_idx) < DEPTH_WORDS);
  assign req_acc   = req_valid & req_ready;
  assign rd_acc    = req_acc & ~req_we;
  assign wr_acc    = req_acc & req_we;
  assign credit_ok = (outstanding < CNTW'(RSP_FIFO_DEPTH));

`ifdef MEM_RESPONDER_STALL_EN
  logic [15:0] lfsr;

  // Taps 16,14,13,11 (bits 15,13,12,10), shifting toward the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= STALL_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign req_ready = credit_ok & lfsr[0];
`else
  assign req_ready = credit_ok;
`endif

  // ---------------------------------------------------------------------
  // Storage (not reset)
  // ---------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int unsigned b = 0; b < BUS_WIDTH_BYTES; b++) begin
        if (req_wstrb[b]) mem[mem_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read pipeline: stage 0 captures the word at the accept edge, so a
  // write accepted on the same edge is not yet visible to that read.
  // ---------------------------------------------------------------------
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [DW-1:0]           pipe_data [READ_LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      if (rd_acc) pipe_data[0] <= in_range ? mem[mem_idx] : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Response FIFO: shift-register form so the head entry is itself the
  // rsp_rdata register.
  // ---------------------------------------------------------------------
  logic              push;
  logic              pop;
  logic [DW-1:0]     push_data;
  logic [CNTW-1:0]   cnt;
  logic [CNTW-1:0]   cnt_next;
  logic [SLOTW-1:0]  wr_slot;
  logic [DW-1:0]     ent [RSP_FIFO_DEPTH];

  assign push      = pipe_vld[READ_LATENCY-1];
  assign push_data = pipe_data[READ_LATENCY-1];
  assign pop       = rsp_valid & rsp_ready;
  assign wr_slot   = pop ? SLOTW'(cnt - 1'b1) : SLOTW'(cnt);
  assign rsp_rdata = ent[0];

  always_comb begin
    cnt_next = cnt;
    case ({push, pop})
      2'b10:   cnt_next = cnt + 1'b1;
      2'b01:   cnt_next = cnt - 1'b1;
      default: cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      rsp_valid <= 1'b0;
      for (int unsigned i = 0; i < RSP_FIFO_DEPTH; i++) ent[i] <= '0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i + 1 < RSP_FIFO_DEPTH; i++) ent[i] <= ent[i+1];
      end
      // Later assignment wins over the shift for the slot being filled.
      if (push) ent[wr_slot] <= push_data;
      cnt       <= cnt_next;
      rsp_valid <= (cnt_next != '0);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (cnt == CNTW'(RSP_FIFO_DEPTH))));

  // ---------------------------------------------------------------------
  // Credits and error flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({rd_acc, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   err_o <= 1'b0;
    else if (req_acc && !in_range) err_o <= 1'b1;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_mem_responder;

  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [15:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic [31:0]   req_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .BUS_WIDTH_BYTES(32),
    .ADDR_WIDTH(16),
    .DEPTH_WORDS(1024),
    .READ_LATENCY(2),
    .RSP_FIFO_DEPTH(4),
    .STALL_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .err_o(err_o)
  );

  function automatic logic [DW-1:0] word_pat(input int k);
    return {8{32'hA500_0000 | 32'(k)}};
  endfunction

  // Write accepted at the next rising edge (caller ensures req_ready=1).
  task automatic wr(input logic [15:0] a, input logic [DW-1:0] d, input logic [31:0] s);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  // Read and collect its response with rsp_ready high, bounded wait.
  task automatic rd(input logic [15:0] a, output logic [DW-1:0] d, output bit got);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0; d = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rsp_valid) begin got = 1'b1; d = rsp_rdata; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    tests++; if (rsp_rdata !== '0) begin fails++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err_o); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency;
    logic [DW-1:0] pat;
    logic [7:0]    b;
    for (int i = 0; i < 32; i++) begin b = 8'(i); pat[8*i +: 8] = b; end
    wr(16'h0040, pat, '1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040;
    @(negedge clk);
    req_valid = 1'b0;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL lat_cycle1: rsp_valid got %b expected 0", rsp_valid); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL lat_cycle2: rsp_valid got %b expected 0", rsp_valid); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL lat_cycle3: rsp_valid got %b expected 1", rsp_valid); end
    tests++; if (rsp_rdata !== pat) begin fails++; $display("FAIL lat_data: got %h expected %h", rsp_rdata, pat); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL lat_pop: rsp_valid got %b expected 0", rsp_valid); end
  endtask

  task automatic test_strobe;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d;
    bit got;
    exp_d = {{224{1'b1}}, 32'h0};
    wr(16'h0060, '1, '1);
    wr(16'h0060, '0, 32'h0000_000F);
    rd(16'h0060, d, got);
    tests++; if (!got || d !== exp_d) begin fails++; $display("FAIL strobe: got %h (valid %b) expected %h", d, got, exp_d); end
  endtask

  task automatic test_back_to_back;
    int  accepted;
    int  extra;
    bit  take;
    bit  got;
    for (int k = 10; k <= 14; k++) wr(16'(k * 32), word_pat(k), '1);
    rsp_ready = 1'b0;
    accepted = 0;
    req_valid = 1'b1; req_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_addr = 16'((10 + accepted) * 32);
      take = req_ready;
      @(negedge clk);
      if (take) accepted++;
    end
    tests++; if (accepted !== 4) begin fails++; $display("FAIL credit_accepts: got %0d expected 4", accepted); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL credit_ready_low: got %b expected 0", req_ready); end
    tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== word_pat(10)) begin
      fails++; $display("FAIL credit_head_hold: got %h (valid %b) expected %h", rsp_rdata, rsp_valid, word_pat(10)); end
    // One-cycle release of rsp_ready frees exactly one credit.
    req_addr = 16'(14 * 32);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      take = req_ready;
      @(negedge clk);
      if (take) extra++;
    end
    req_valid = 1'b0;
    tests++; if (extra !== 1) begin fails++; $display("FAIL credit_release: got %0d extra accepts expected 1", extra); end
    rsp_ready = 1'b1;
    for (int k = 11; k <= 14; k++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        if (rsp_valid) got = 1'b1; else @(negedge clk);
      end
      tests++; if (!got || rsp_rdata !== word_pat(k)) begin
        fails++; $display("FAIL order_word%0d: got %h (valid %b) expected %h", k, rsp_rdata, got, word_pat(k)); end
      @(negedge clk);
    end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL order_drained: rsp_valid got %b expected 0", rsp_valid); end
  endtask

  task automatic test_out_of_range;
    logic [DW-1:0] d;
    logic [DW-1:0] w0;
    bit got;
    w0 = {8{32'h1234_5678}};
    wr(16'h0000, w0, '1);
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL oor_err_before: got %b expected 0", err_o); end
    rd(16'h8000, d, got);
    tests++; if (!got || d !== '0) begin fails++; $display("FAIL oor_read_data: got %h (valid %b) expected 0", d, got); end
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL oor_err_set: got %b expected 1", err_o); end
    wr(16'h8000, '1, '1);
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL oor_err_sticky: got %b expected 1", err_o); end
    rd(16'h0000, d, got);
    tests++; if (!got || d !== w0) begin fails++; $display("FAIL oor_write_dropped: got %h expected %h", d, w0); end
  endtask

  task automatic test_raw;
    logic [DW-1:0] d;
    bit got;
    wr(16'h00A0, {8{32'h0BAD_0BAD}}, '1);
    wr(16'h00A0, {8{32'h600D_5555}}, '1);
    rd(16'h00A0, d, got);
    tests++; if (!got || d !== {8{32'h600D_5555}}) begin
      fails++; $display("FAIL raw: got %h (valid %b) expected %h", d, got, {8{32'h600D_5555}}); end
  endtask

  task automatic test_reset_midflight;
    int stale;
    int accepted;
    bit take;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0;
    for (int k = 10; k <= 12; k++) begin
      req_addr = 16'(k * 32);
      @(negedge clk);
    end
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL midreset_rsp_valid: got %b expected 0", rsp_valid); end
    tests++; if (rsp_rdata !== '0) begin fails++; $display("FAIL midreset_rsp_rdata: got %h expected 0", rsp_rdata); end
    @(negedge clk);
    reset = 1'b0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b expected 1", req_ready); end
    rsp_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    tests++; if (stale !== 0) begin fails++; $display("FAIL midreset_stale: got %0d responses expected 0", stale); end
    // Full credit pool must be available again.
    rsp_ready = 1'b0;
    accepted = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0000;
    for (int c = 0; c < 6; c++) begin
      take = req_ready;
      @(negedge clk);
      if (take) accepted++;
    end
    req_valid = 1'b0;
    tests++; if (accepted !== 4) begin fails++; $display("FAIL midreset_credits: got %0d accepts expected 4", accepted); end
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_strobe();
    test_back_to_back();
    test_out_of_range();
    test_raw();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port memory responder: the slave end of the matrix engine's wide data bus. It answers the read and write requests issued on the A/B/C buses by the systolic-array data movers. It provides a behavioural-but-synthesizable word store with a fixed read-pipeline latency, byte-strobed writes and a response FIFO with credit-based back-pressure. One instance sits behind each data bus, in the SoC wrapper and in the bench.

## Interface
Parameters:
- BUS_WIDTH_BYTES, 32, data word width in bytes (data width = 8*BUS_WIDTH_BYTES)
- ADDR_WIDTH, 16, byte-address width
- DEPTH_WORDS, 1024, number of storage words
- READ_LATENCY, 2, cycles from read accept to response-FIFO write; must be ≥1
- RSP_FIFO_DEPTH, 4, response FIFO entries; must be ≥1
- STALL_SEED, 16'hACE1, LFSR seed (used only with MEM_RESPONDER_STALL_EN)

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  8*BUS_WIDTH_BYTES  write data
- req_wstrb  in  BUS_WIDTH_BYTES  per-byte write enable
- rsp_valid  out  1  read data available
- rsp_ready  in  1  requester takes the response
- rsp_rdata  out  8*BUS_WIDTH_BYTES  read data
- err_o  out  1  sticky out-of-range flag

## Operation
- Handshake: a request transfers at a rising edge when req_valid & req_ready. A response transfers when rsp_valid & rsp_ready.
- Word index = req_addr >> log2(BUS_WIDTH_BYTES). The low address bits are ignored, so addresses are word-aligned implicitly.
- Write: on accept, each byte i with req_wstrb[i]=1 is updated. Writes produce no response.
- Read: on accept, the addressed word is sampled in the same cycle. The sample passes through READ_LATENCY pipeline stages, then is pushed into the response FIFO.
- Ordering: responses return strictly in request order.
- Read-after-write: a write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Out of range (word index ≥ DEPTH_WORDS):
  - A write is dropped.
  - A read returns all-zero data but still produces a response.
  - Either case sets err_o, which stays set until reset.
- Credit counter `outstanding` tracks reads in the pipeline plus reads held in the FIFO.
  - +1 on read accept; −1 on response handshake.
  - Both in the same cycle leaves it unchanged.
- req_ready = (outstanding < RSP_FIFO_DEPTH), further gated by the stall mask when that feature is compiled in.
  - req_ready does not depend combinationally on req_valid, req_we or req_addr.
  - When req_ready is low, writes are blocked as well as reads.
- FIFO full can never be reached with a push pending: the credit scheme guarantees it. An overflow is an assertion failure.
- Storage is not cleared by reset; its contents are undefined until written.

## Timing
- Reset values: req_ready=1 (0 if the stall LFSR's first mask bit is 0), rsp_valid=0, rsp_rdata=0, err_o=0. Reset also sets outstanding=0, empties the pipeline and the FIFO, and loads STALL_SEED into the LFSR.
- Read latency: read accepted at edge N → FIFO push at edge N+READ_LATENCY → rsp_valid=1 in the following cycle. Minimum request-to-response latency is therefore READ_LATENCY cycles.
- Throughput: one request per cycle while credits remain. With rsp_ready held high, reads sustain 1 per cycle if RSP_FIFO_DEPTH ≥ READ_LATENCY+1.
- rsp_valid and rsp_rdata are registered (FIFO head) and stay stable while rsp_valid & ~rsp_ready.
- err_o rises in the cycle after the out-of-range request is accepted.
- Reset asserted mid-operation drops all in-flight reads, and rsp_valid falls immediately (asynchronous reset). Writes already accepted remain in storage.

## Configuration
- MEM_RESPONDER_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - Bit 0 of the LFSR ANDs into req_ready, giving pseudo-random request back-pressure for bus-master stress.
- Not defined: no LFSR is present and req_ready depends only on credits.

## Test plan
- Write 0x00..0x1F bytes at addr 0x0040 with wstrb all-ones, then read 0x0040 → after READ_LATENCY=2 cycles rsp_rdata = 0x1F1E…0100 and rsp_valid=1.
- Write all-0xFF to word 3, then write 0x00 with wstrb=32'h0000_000F → a read of word 3 returns 0xFF in bytes 4..31 and 0x00 in bytes 0..3.
- Hold rsp_ready=0 and issue 6 back-to-back reads → exactly 4 are accepted and req_ready=0. Releasing rsp_ready for 1 cycle → exactly 1 more read is accepted. Data returns in issue order.
- Read at byte addr 0x8000 (word 1024, DEPTH_WORDS=1024) → response data 0 and err_o=1. Write to the same address → storage unchanged and err_o stays 1.
- Write word 5 at edge N and read word 5 at edge N+1 → the response carries the new data.
- Issue 3 reads, assert reset for 1 cycle before the responses return → rsp_valid=0, no stale responses afterwards, and req_ready=1 with outstanding=0.
